// File: rtl/spectrum_band_mapper_if.sv
// Bus between the FFT/graphics side (master) and the band mapper (slave).
// fft_done is a level whose rising edge starts a frame; frame_valid is a one-cycle strobe, no back-pressure.
interface spectrum_band_mapper_if #(
    parameter int N         = 256,
    parameter int WIDTH     = 18,
    parameter int NUM_BANDS = 16,
    parameter int GFX_WIDTH = 6
);
    logic                 fft_done;
    logic [WIDTH:0]       freq_mag   [0:N-1];
    logic [3:0]           gain_shift;
    logic [GFX_WIDTH-1:0] band_level [0:NUM_BANDS-1];
    logic                 frame_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output fft_done, freq_mag, gain_shift,
        input  band_level, frame_valid, busy, overrun
    );

    modport slave (
        input  fft_done, freq_mag, gain_shift,
        output band_level, frame_valid, busy, overrun
    );
endinterface

// File: rtl/spectrum_band_mapper.sv
// Folds FFT magnitude bins into saturated display band levels, one bin per cycle.
// Optional macro PEAK_HOLD_EN: bands decay by one per frame instead of dropping instantly.
module spectrum_band_mapper #(
    parameter int N         = 256,
    parameter int WIDTH     = 18,
    parameter int NUM_BANDS = 16,
    parameter int BAND_BINS = 4,
    parameter int FIRST_BIN = 1,
    parameter int GFX_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    spectrum_band_mapper_if.slave bus,
    output logic [1:0]            dbg_state_o
);
    localparam int BIN_W  = (N > 1) ? $clog2(N) : 1;
    localparam int SUB_W  = (BAND_BINS > 1) ? $clog2(BAND_BINS) : 1;
    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

    state_e               state_q, state_d;
    logic                 fft_done_q;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [SUB_W-1:0]     sub_q, sub_d;
    logic [BAND_W-1:0]    band_q, band_d;
    logic [WIDTH:0]       max_q, max_d;
    logic [3:0]           shift_q, shift_d;
    logic                 overrun_q, overrun_d;
    logic                 valid_q;
    logic [GFX_WIDTH-1:0] shadow_q [0:NUM_BANDS-1];
    logic [GFX_WIDTH-1:0] level_q  [0:NUM_BANDS-1];

    logic                 start;
    logic [WIDTH:0]       cur_mag;
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       shifted;
    logic [GFX_WIDTH-1:0] band_val;
    logic                 shadow_we;
    logic                 commit;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        sub_d     = sub_q;
        band_d    = band_q;
        max_d     = max_q;
        shift_d   = shift_q;
        overrun_d = overrun_q;
        shadow_we = 1'b0;
        commit    = 1'b0;

        start   = bus.fft_done & ~fft_done_q;
        cur_mag = bus.freq_mag[bin_q];
        acc     = (cur_mag > max_q) ? cur_mag : max_q;
        shifted = acc >> shift_q;
        // Anything above the display range clips to full scale rather than wrapping.
        band_val = (shifted[WIDTH:GFX_WIDTH] != '0) ? '1 : shifted[GFX_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    bin_d   = BIN_W'(FIRST_BIN);
                    sub_d   = '0;
                    band_d  = '0;
                    max_d   = '0;
                    shift_d = bus.gain_shift;
                end
            end
            SCAN: begin
                if (start) overrun_d = 1'b1;
                bin_d = bin_q + BIN_W'(1);
                if (sub_q == SUB_W'(BAND_BINS - 1)) begin
                    shadow_we = 1'b1;
                    max_d     = '0;
                    sub_d     = '0;
                    band_d    = band_q + BAND_W'(1);
                    if (band_q == BAND_W'(NUM_BANDS - 1)) state_d = COMMIT;
                end else begin
                    max_d = acc;
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            COMMIT: begin
                if (start) overrun_d = 1'b1;
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fft_done_q <= 1'b0;
            bin_q      <= '0;
            sub_q      <= '0;
            band_q     <= '0;
            max_q      <= '0;
            shift_q    <= '0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                shadow_q[i] <= '0;
                level_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fft_done_q <= bus.fft_done;
            bin_q      <= bin_d;
            sub_q      <= sub_d;
            band_q     <= band_d;
            max_q      <= max_d;
            shift_q    <= shift_d;
            overrun_q  <= overrun_d;
            valid_q    <= commit;
            if (shadow_we) shadow_q[band_q] <= band_val;
            if (commit) begin
                for (int i = 0; i < NUM_BANDS; i++) begin
`ifdef PEAK_HOLD_EN
                    // shadow >= 0 always wins when the level is already 0, so no underflow.
                    if (shadow_q[i] >= level_q[i]) level_q[i] <= shadow_q[i];
                    else                           level_q[i] <= level_q[i] - GFX_WIDTH'(1);
`else
                    level_q[i] <= shadow_q[i];
`endif
                end
            end
        end
    end

    assign bus.band_level  = level_q;
    assign bus.frame_valid = valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_spectrum_band_mapper.sv
// Self-checking bench for spectrum_band_mapper against a per-band max/shift/saturate model.
// Honours PEAK_HOLD_EN the same way the design does.
module tb_spectrum_band_mapper;
    localparam int N         = 256;
    localparam int WIDTH     = 18;
    localparam int NUM_BANDS = 16;
    localparam int BAND_BINS = 4;
    localparam int FIRST_BIN = 1;
    localparam int GFX_WIDTH = 6;
    localparam int LAT       = NUM_BANDS * BAND_BINS + 1;
    localparam int LVL_MAX   = (1 << GFX_WIDTH) - 1;
    localparam int WINDOW    = 140;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    spectrum_band_mapper_if #(
        .N(N), .WIDTH(WIDTH), .NUM_BANDS(NUM_BANDS), .GFX_WIDTH(GFX_WIDTH)
    ) bus ();

    spectrum_band_mapper #(
        .N(N), .WIDTH(WIDTH), .NUM_BANDS(NUM_BANDS), .BAND_BINS(BAND_BINS),
        .FIRST_BIN(FIRST_BIN), .GFX_WIDTH(GFX_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int                   n_checks = 0;
    int                   n_err    = 0;
    int                   mag       [N];
    int                   model_lvl [NUM_BANDS];
    logic [GFX_WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: each band is the max of its bins, shifted, clipped to the display range.
    function automatic void model_frame(input int shift);
        for (int b = 0; b < NUM_BANDS; b++) begin
            int mx = 0;
            int v;
            for (int j = 0; j < BAND_BINS; j++)
                if (mag[FIRST_BIN + b * BAND_BINS + j] > mx) mx = mag[FIRST_BIN + b * BAND_BINS + j];
            v = mx >> shift;
            if (v > LVL_MAX) v = LVL_MAX;
`ifdef PEAK_HOLD_EN
            if (v < model_lvl[b]) v = model_lvl[b] - 1;
`endif
            model_lvl[b] = v;
        end
    endfunction

    function automatic void push_model();
        for (int b = 0; b < NUM_BANDS; b++) exp_q.push_back(GFX_WIDTH'(model_lvl[b]));
    endfunction

    task automatic compare_levels(input string tag);
        for (int b = 0; b < NUM_BANDS; b++) begin
            logic [GFX_WIDTH-1:0] e;
            if (exp_q.size() == 0) begin
                check({tag, " queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s band%0d", tag, b), 32'(bus.band_level[b]), 32'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_mag();
        for (int i = 0; i < N; i++) bus.freq_mag[i] = (WIDTH + 1)'(mag[i]);
    endtask

    task automatic clear_mag();
        for (int i = 0; i < N; i++) mag[i] = 0;
    endtask

    task automatic random_mag();
        for (int i = 0; i < N; i++)
            mag[i] = int'($urandom_range(0, (1 << $urandom_range(3, WIDTH + 1)) - 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        bus.fft_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int b = 0; b < NUM_BANDS; b++) model_lvl[b] = 0;
    endtask

    // mode 0: plain frame; 1: fft_done re-rises mid-scan; 2: re-rises on the commit edge;
    // 3: reset asserted around scan cycle 30.
    task automatic run_frame(input string tag, input int shift, input int mode);
        int first_k = 0;
        int pulses  = 0;
        if (mode != 3) begin
            model_frame(shift);
            push_model();
        end
        @(negedge clk);
        bus.gain_shift = 4'(shift);
        load_mag();
        bus.fft_done = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= WINDOW; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (k == 1) check({tag, " busy_in_scan"}, 32'(bus.busy), 32'd1);
            case (mode)
                1: begin
                    if (k == 18) bus.fft_done = 1'b0;
                    if (k == 20) bus.fft_done = 1'b1;
                end
                2: begin
                    if (k == 60) bus.fft_done = 1'b0;
                    if (k == 64) bus.fft_done = 1'b1;
                end
                3: begin
                    if (k == 30) begin
                        rst          = 1'b0;
                        bus.fft_done = 1'b0;
                    end
                    if (k == 32) rst = 1'b1;
                end
                default: ;
            endcase
        end
        if (mode == 3) begin
            check({tag, " no_frame_valid"}, 32'(pulses), 32'd0);
            for (int b = 0; b < NUM_BANDS; b++) model_lvl[b] = 0;
            push_model();
        end else begin
            check({tag, " latency"}, 32'(first_k), 32'(LAT));
            check({tag, " pulse_count"}, 32'(pulses), 32'd1);
        end
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        compare_levels(tag);
        @(negedge clk);
        bus.fft_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.fft_done   = 1'b0;
        bus.gain_shift = 4'd0;
        clear_mag();
        load_mag();
        for (int b = 0; b < NUM_BANDS; b++) model_lvl[b] = 0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset frame_valid", 32'(bus.frame_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset overrun", 32'(bus.overrun), 32'd0);
        push_model();
        compare_levels("reset");
        @(negedge clk);
        rst = 1'b1;

        // All-zero spectrum.
        run_frame("zero", 0, 0);

        // Single bin inside band 1, divided by 4.
        clear_mag();
        mag[5] = 200;
        run_frame("bin5", 2, 0);
        check("bin5 band1_direct", 32'(bus.band_level[1]), 32'd50);

        // Saturation, then DC bin ignored.
        clear_mag();
        mag[1] = 100000;
        run_frame("sat", 0, 0);
        check("sat band0_direct", 32'(bus.band_level[0]), 32'(LVL_MAX));
        clear_mag();
        mag[0] = 100000;
        run_frame("dc_only", 0, 0);

        // Decay behaviour across two frames.
        do_reset();
        clear_mag();
        mag[1] = 40;
        run_frame("decay1", 0, 0);
        mag[1] = 10;
        run_frame("decay2", 0, 0);
`ifdef PEAK_HOLD_EN
        check("decay2 band0_direct", 32'(bus.band_level[0]), 32'd39);
`else
        check("decay2 band0_direct", 32'(bus.band_level[0]), 32'd10);
`endif

        // Random spectra and gain shifts.
        for (int f = 0; f < 6; f++) begin
            random_mag();
            run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 15)), 0);
        end

        // Output must hold while magnitudes change between frames.
        random_mag();
        load_mag();
        repeat (20) @(posedge clk);
        #1;
        push_model();
        compare_levels("hold");

        // Re-trigger during scan.
        random_mag();
        run_frame("overrun_scan", int'($urandom_range(0, 6)), 1);
        check("overrun_scan sticky", 32'(bus.overrun), 32'd1);
        random_mag();
        run_frame("after_overrun", int'($urandom_range(0, 6)), 0);
        check("overrun still_set", 32'(bus.overrun), 32'd1);
        do_reset();
        #1;
        check("overrun cleared", 32'(bus.overrun), 32'd0);

        // Re-trigger on the commit edge.
        random_mag();
        run_frame("overrun_commit", int'($urandom_range(0, 6)), 2);
        check("overrun_commit sticky", 32'(bus.overrun), 32'd1);
        do_reset();

        // Reset mid-scan, then a normal frame.
        random_mag();
        run_frame("abort", 0, 3);
        check("abort state_idle", 32'(dbg_state), 32'd0);
        random_mag();
        run_frame("post_abort", int'($urandom_range(0, 6)), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/spectrum_band_mapper.md
SPECTRUM_BAND_MAPPER -- requirements
Module: spectrum_band_mapper

Interface
REQ-001 SHALL have parameter N, default 256: FFT length; freq_mag depth.
REQ-002 SHALL have parameter WIDTH, default 18: computation width; each freq_mag entry is WIDTH+1 bits, unsigned.
REQ-003 SHALL have parameter NUM_BANDS, default 16: display band count.
REQ-004 SHALL have parameter BAND_BINS, default 4: contiguous FFT bins per band.
REQ-005 SHALL have parameter FIRST_BIN, default 1: first bin of band 0 (DC skipped); FIRST_BIN+NUM_BANDS*BAND_BINS <= N is a legal-configuration constraint.
REQ-006 SHALL have parameter GFX_WIDTH, default 6: band level width.
REQ-007 Ports: clk  in  1  clock; all logic on rising edge.
REQ-008 Ports: rst  in  1  synchronous, active-low reset.
REQ-009 Ports: fft_done  in  1  FFT done level; rising edge marks a new frame.
REQ-010 Ports: freq_mag  in  [WIDTH:0] x [0:N-1]  FFT magnitudes, held stable by the FFT until its next start.
REQ-011 Ports: gain_shift  in  4  right-shift applied to band maxima.
REQ-012 Ports: band_level  out  [GFX_WIDTH-1:0] x [0:NUM_BANDS-1]  registered band heights to graphics.
REQ-013 Ports: frame_valid  out  1  one-cycle pulse when band_level updates.
REQ-014 Ports: busy  out  1  high in SCAN and COMMIT.
REQ-015 Ports: overrun  out  1  sticky; fft_done rose while busy.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, COMMIT.
REQ-017 SHALL register fft_done each cycle; start = fft_done & ~fft_done_q.
REQ-018 In IDLE on start: SHALL enter SCAN, set bin index to FIRST_BIN, band index 0, clear running max, capture gain_shift for the whole frame.
REQ-019 In SCAN SHALL read exactly one bin per cycle, max-accumulating into the running max, incrementing the bin index.
REQ-020 On the last bin of a band SHALL store sat(max >> gain_shift_captured) into shadow[band] and clear the running max for the next band.
REQ-021 sat(x) SHALL equal x when x < 2^GFX_WIDTH, else 2^GFX_WIDTH-1 (all ones); truncation is forbidden.
REQ-022 After NUM_BANDS*BAND_BINS SCAN cycles SHALL enter COMMIT; in COMMIT SHALL update all band_level entries, pulse frame_valid, and return to IDLE.
REQ-023 Latency: band_level/frame_valid SHALL change at edge start+NUM_BANDS*BAND_BINS+1 (65 cycles at defaults).
REQ-024 start while busy SHALL be ignored and SHALL set overrun; the current frame completes unchanged.
REQ-025 start on the same edge COMMIT returns to IDLE SHALL be treated as busy (ignored, overrun set).
REQ-026 band_level SHALL hold its value between COMMITs regardless of freq_mag changes.

Reset
REQ-027 rst low at a clock edge SHALL force IDLE, band_level all 0, shadow all 0, frame_valid 0, busy 0, overrun 0, fft_done_q 0.
REQ-028 Reset mid-SCAN SHALL abort the frame with no frame_valid pulse; after release a new fft_done rising edge is required.

Configuration
REQ-029 Macro PEAK_HOLD_EN defined: in COMMIT each band_level SHALL become shadow if shadow >= band_level, else band_level-1 (floor 0).
REQ-030 PEAK_HOLD_EN undefined: in COMMIT band_level SHALL equal shadow directly; no decay logic synthesised.

Verification (defaults N=256, WIDTH=18, NUM_BANDS=16, BAND_BINS=4, FIRST_BIN=1, GFX_WIDTH=6)
REQ-031 All freq_mag=0, fft_done 0->1 -> frame_valid exactly 65 cycles later, one cycle wide; all band_level=0.
REQ-032 freq_mag[5]=200, others 0, gain_shift=2 -> band_level[1]=50, all other bands 0.
REQ-033 freq_mag[1]=100000, gain_shift=0 -> band_level[0]=63 (saturated); freq_mag[0]=100000 alone -> all bands 0.
REQ-034 Frame1 freq_mag[1]=40, frame2 freq_mag[1]=10, shift 0 -> band_level[0]=39 after frame2 with PEAK_HOLD_EN, 10 without.
REQ-035 fft_done toggled low then high 20 cycles into SCAN -> single frame_valid at cycle 65, overrun=1 until reset.
REQ-036 rst low at SCAN cycle 30 -> band_level all 0, busy 0, no frame_valid; next fft_done rising edge yields a normal frame.
